// File: rtl/ahb_manager_arbiter_if.sv
// rtl/ahb_manager_arbiter_if.sv - requester ports and AHB-Lite manager bus of ahb_manager_arbiter
//
// Purpose: bundles the fetch port, the data load/store port and the AHB-Lite
// manager-side signals so the arbiter and its environment share one definition.
// Ports (signals):
//   fetch   : i_req, i_addr -> i_done, i_err
//   data    : d_ren, d_wen, d_addr, d_wdata, d_size -> d_done, d_err
//   shared  : rdata (read data to both requesters)
//   AHB out : haddr, htrans, hwrite, hsize, hwdata
//   AHB in  : hrdata, hready, hresp
// Modports: master = the arbiter side, slave = requesters plus bus mux side.
interface ahb_manager_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_done;
   logic        i_err;
   logic        d_ren;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic        d_done;
   logic        d_err;
   logic [31:0] rdata;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [1:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, d_size,
      input  hrdata, hready, hresp,
      output i_done, i_err, d_done, d_err, rdata,
      output haddr, htrans, hwrite, hsize, hwdata
   );

   modport slave (
      output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, d_size,
      output hrdata, hready, hresp,
      input  i_done, i_err, d_done, d_err, rdata,
      input  haddr, htrans, hwrite, hsize, hwdata
   );
endinterface

// File: rtl/ahb_manager_arbiter.sv
// rtl/ahb_manager_arbiter.sv - two-requester AHB-Lite manager (fetch + data) with single-transfer sequencing
//
// Purpose: arbitrates between the instruction-fetch port and the data port and
// runs one non-pipelined AHB-Lite single transfer at a time: IDLE -> ADDR
// (NONSEQ) -> DATA -> IDLE. The granted port gets a one-cycle *_done with
// *_err = hresp in the DATA cycle where hready is high.
// Parameters:
//   RR_ARB : 0 = fixed priority, data port wins ties; 1 = round-robin on ties.
// Ports:
//   clk  : system clock, rising edge
//   nrst : asynchronous active-low reset
//   ahb  : requester and AHB-Lite signals (master modport of ahb_manager_arbiter_if)
module ahb_manager_arbiter #(
   parameter bit RR_ARB = 1'b0
) (
   input  logic                   clk,
   input  logic                   nrst,
   ahb_manager_arbiter_if.master  ahb
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10
   } state_t;

   localparam logic       GNT_I        = 1'b0;
   localparam logic       GNT_D        = 1'b1;
   localparam logic [1:0] HTRANS_IDLE  = 2'b00;
   localparam logic [1:0] HTRANS_NSEQ  = 2'b10;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;

   logic        d_req;
   logic        pick_d;

   assign d_req = ahb.d_ren | ahb.d_wen;

   // Grant choice for the current IDLE cycle. On a tie, round-robin hands the
   // bus to whichever port did not win last time.
   always_comb begin
      pick_d = d_req;
      if (d_req && ahb.i_req) begin
         if (RR_ARB) begin
            pick_d = (last_grant_q == GNT_I);
         end else begin
            pick_d = GNT_D;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= S_IDLE;
         grant_q      <= GNT_I;
         last_grant_q <= GNT_I;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         size_q       <= size_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      size_d       = size_q;
      ahb.htrans   = HTRANS_IDLE;
      ahb.i_done   = 1'b0;
      ahb.i_err    = 1'b0;
      ahb.d_done   = 1'b0;
      ahb.d_err    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (d_req || ahb.i_req) begin
               state_d      = S_ADDR;
               grant_d      = pick_d;
               last_grant_d = pick_d;
               if (pick_d == GNT_D) begin
                  addr_d  = ahb.d_addr;
                  write_d = ahb.d_wen;
                  size_d  = ahb.d_size;
                  wdata_d = ahb.d_wdata;
               end else begin
                  // Instruction fetch is always a word read.
                  addr_d  = ahb.i_addr;
                  write_d = 1'b0;
                  size_d  = 2'b10;
                  wdata_d = '0;
               end
            end
         end

         S_ADDR: begin
            ahb.htrans = HTRANS_NSEQ;
            if (ahb.hready) begin
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            // The first cycle of a two-cycle error response has hready low,
            // so we simply keep waiting and report on the second cycle.
            if (ahb.hready) begin
               state_d = S_IDLE;
               if (grant_q == GNT_D) begin
                  ahb.d_done = 1'b1;
                  ahb.d_err  = ahb.hresp;
               end else begin
                  ahb.i_done = 1'b1;
                  ahb.i_err  = ahb.hresp;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ahb.haddr  = addr_q;
   assign ahb.hwrite = write_q;
   assign ahb.hsize  = size_q;
   assign ahb.hwdata = wdata_q;
   assign ahb.rdata  = ahb.hrdata;

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// tb/tb_ahb_manager_arbiter.sv - self-checking bench for ahb_manager_arbiter (fixed-priority and round-robin instances)
module tb_ahb_manager_arbiter;

   typedef struct {
      logic        port_d;
      logic        err;
      logic        chk_rd;
      logic [31:0] rd;
   } exp_t;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   ahb_manager_arbiter_if b0 ();
   ahb_manager_arbiter_if b1 ();

   ahb_manager_arbiter #(.RR_ARB(1'b0)) dut0 (.clk(clk), .nrst(nrst), .ahb(b0.master));
   ahb_manager_arbiter #(.RR_ARB(1'b1)) dut1 (.clk(clk), .nrst(nrst), .ahb(b1.master));

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t q0[$];
   exp_t q1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic quiet_inputs();
      b0.i_req = 0; b0.i_addr = 0; b0.d_ren = 0; b0.d_wen = 0; b0.d_addr = 0;
      b0.d_wdata = 0; b0.d_size = 0; b0.hrdata = 0; b0.hready = 1; b0.hresp = 0;
      b1.i_req = 0; b1.i_addr = 0; b1.d_ren = 0; b1.d_wen = 0; b1.d_addr = 0;
      b1.d_wdata = 0; b1.d_size = 0; b1.hrdata = 0; b1.hready = 1; b1.hresp = 0;
   endtask

   task automatic wait_done(input int sel, output logic got_d);
      int n;
      n = 0;
      while (!((sel == 0) ? (b0.i_done | b0.d_done) : (b1.i_done | b1.d_done)) && n < 20) begin
         cyc();
         n++;
      end
      chk($sformatf("dut%0d_done_within_budget", sel), 32'(n < 20), 32'd1);
      got_d = (sel == 0) ? b0.d_done : b1.d_done;
   endtask

   // Scoreboard side: every done pulse pops one expected completion.
   task automatic monitor(input int sel);
      exp_t        e;
      logic        idn, ddn, er;
      logic [31:0] rd;
      idn = (sel == 0) ? b0.i_done : b1.i_done;
      ddn = (sel == 0) ? b0.d_done : b1.d_done;
      er  = (sel == 0) ? (b0.i_err | b0.d_err) : (b1.i_err | b1.d_err);
      rd  = (sel == 0) ? b0.rdata : b1.rdata;
      if (idn || ddn) begin
         if (((sel == 0) ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("dut%0d_unexpected_done", sel), 32'({idn, ddn}), 32'd0);
         end else begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d_grant_port", sel), 32'({idn, ddn}), 32'({~e.port_d, e.port_d}));
            chk($sformatf("dut%0d_err", sel), 32'(er), 32'(e.err));
            if (e.chk_rd) chk($sformatf("dut%0d_rdata", sel), rd, e.rd);
         end
      end
   endtask

   always @(negedge clk) if (nrst) monitor(0);
   always @(negedge clk) if (nrst) monitor(1);

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic gd;
      int   nd;
      quiet_inputs();
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_htrans", 32'(b0.htrans), 32'd0);
      chk("rst_haddr", b0.haddr, 32'd0);
      chk("rst_hwrite", 32'(b0.hwrite), 32'd0);
      chk("rst_hsize", 32'(b0.hsize), 32'd0);
      chk("rst_hwdata", b0.hwdata, 32'd0);
      chk("rst_dones", 32'({b0.i_done, b0.d_done, b0.i_err, b0.d_err}), 32'd0);
      chk("rst_dut1_htrans", 32'(b1.htrans), 32'd0);
      nrst = 1'b1;

      // Zero-wait fetch read
      b0.i_req = 1; b0.i_addr = 32'h0000_0100; b0.hrdata = 32'h0051_3093; b0.hready = 1;
      q0.push_back('{1'b0, 1'b0, 1'b1, 32'h0051_3093});
      #1 chk("t1_c0_htrans", 32'(b0.htrans), 32'd0);
      cyc();
      chk("t1_c1_htrans", 32'(b0.htrans), 32'd2);
      chk("t1_c1_haddr", b0.haddr, 32'h100);
      chk("t1_c1_hsize", 32'(b0.hsize), 32'd2);
      chk("t1_c1_hwrite", 32'(b0.hwrite), 32'd0);
      chk("t1_c1_no_done", 32'(b0.i_done), 32'd0);
      cyc();
      chk("t1_c2_i_done", 32'(b0.i_done), 32'd1);
      chk("t1_c2_d_done", 32'(b0.d_done), 32'd0);
      chk("t1_c2_rdata", b0.rdata, 32'h0051_3093);
      chk("t1_c2_htrans", 32'(b0.htrans), 32'd0);
      b0.i_req = 0;
      cyc();
      chk("t1_c3_htrans", 32'(b0.htrans), 32'd0);
      chk("t1_c3_i_done", 32'(b0.i_done), 32'd0);

      // Data byte write with two wait states in DATA
      b0.d_wen = 1; b0.d_addr = 32'h203; b0.d_size = 2'b00; b0.d_wdata = 32'hAB00_0000;
      q0.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
      cyc();
      chk("t2_addr_htrans", 32'(b0.htrans), 32'd2);
      chk("t2_addr_hwrite", 32'(b0.hwrite), 32'd1);
      chk("t2_addr_hsize", 32'(b0.hsize), 32'd0);
      chk("t2_addr_haddr", b0.haddr, 32'h203);
      cyc();
      b0.hready = 0;
      #1;
      chk("t2_w1_d_done", 32'(b0.d_done), 32'd0);
      chk("t2_w1_hwdata", b0.hwdata, 32'hAB00_0000);
      chk("t2_w1_htrans", 32'(b0.htrans), 32'd0);
      cyc();
      chk("t2_w2_d_done", 32'(b0.d_done), 32'd0);
      chk("t2_w2_hwdata", b0.hwdata, 32'hAB00_0000);
      cyc();
      b0.hready = 1;
      #1;
      chk("t2_done_d_done", 32'(b0.d_done), 32'd1);
      chk("t2_done_hwdata", b0.hwdata, 32'hAB00_0000);
      chk("t2_done_hwrite", 32'(b0.hwrite), 32'd1);
      b0.d_wen = 0;
      cyc();
      chk("t2_idle_d_done", 32'(b0.d_done), 32'd0);

      // Two-cycle error response on an unsupported-size write
      b0.d_wen = 1; b0.d_addr = 32'h301; b0.d_size = 2'b11; b0.d_wdata = 32'h1122_3344;
      q0.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      cyc();
      chk("t5_addr_hsize", 32'(b0.hsize), 32'd3);
      chk("t5_addr_htrans", 32'(b0.htrans), 32'd2);
      cyc();
      b0.hresp = 1; b0.hready = 0;
      #1;
      chk("t5_err1_done", 32'({b0.d_done, b0.d_err}), 32'd0);
      cyc();
      b0.hready = 1;
      #1;
      chk("t5_err2_done_err", 32'({b0.d_done, b0.d_err}), 32'd3);
      chk("t5_err2_i_done", 32'(b0.i_done), 32'd0);
      b0.d_wen = 0;
      cyc();
      b0.hresp = 0;
      b0.i_req = 1; b0.i_addr = 32'h500; b0.hrdata = 32'h0BAD_F00D;
      q0.push_back('{1'b0, 1'b0, 1'b1, 32'h0BAD_F00D});
      #1;
      chk("t5_idle_htrans", 32'(b0.htrans), 32'd0);
      chk("t5_idle_d_done", 32'(b0.d_done), 32'd0);
      cyc();
      chk("t5_next_htrans", 32'(b0.htrans), 32'd2);
      chk("t5_next_haddr", b0.haddr, 32'h500);
      chk("t5_next_hwrite", 32'(b0.hwrite), 32'd0);
      chk("t5_next_hsize", 32'(b0.hsize), 32'd2);
      cyc();
      chk("t5_next_i_done", 32'(b0.i_done), 32'd1);
      b0.i_req = 0;
      cyc();

      // Fixed priority: both request, data held for three transfers
      b0.i_req = 1; b0.i_addr = 32'h400;
      b0.d_ren = 1; b0.d_addr = 32'h800; b0.d_size = 2'b10; b0.hrdata = 32'hCAFE_0001;
      q0.push_back('{1'b1, 1'b0, 1'b1, 32'hCAFE_0001});
      q0.push_back('{1'b1, 1'b0, 1'b1, 32'hCAFE_0001});
      q0.push_back('{1'b1, 1'b0, 1'b1, 32'hCAFE_0001});
      q0.push_back('{1'b0, 1'b0, 1'b1, 32'hCAFE_0001});
      nd = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         wait_done(0, gd);
         if (gd) begin
            nd++;
            if (nd == 3) b0.d_ren = 0;
         end else begin
            b0.i_req = 0;
         end
      end
      chk("t3_data_transfers", 32'(nd), 32'd3);
      b0.i_req = 0; b0.d_ren = 0;
      cyc();

      // Reset in DATA while waiting
      b0.d_ren = 1; b0.d_addr = 32'h700; b0.d_size = 2'b10;
      cyc();
      chk("t6_addr_htrans", 32'(b0.htrans), 32'd2);
      cyc();
      b0.hready = 0;
      #1;
      chk("t6_wait_d_done", 32'(b0.d_done), 32'd0);
      #1 nrst = 1'b0;
      #1;
      chk("t6_rst_htrans", 32'(b0.htrans), 32'd0);
      chk("t6_rst_haddr", b0.haddr, 32'd0);
      chk("t6_rst_done_err", 32'({b0.i_done, b0.d_done, b0.i_err, b0.d_err}), 32'd0);
      b0.hready = 1; b0.d_ren = 0;
      #1;
      chk("t6_rst_hready_done", 32'(b0.d_done), 32'd0);
      cyc();
      cyc();
      nrst = 1'b1;
      b0.i_req = 1; b0.i_addr = 32'h600; b0.hrdata = 32'h7777_0600;
      q0.push_back('{1'b0, 1'b0, 1'b1, 32'h7777_0600});
      #1 chk("t6_post_idle_htrans", 32'(b0.htrans), 32'd0);
      cyc();
      chk("t6_post_addr_htrans", 32'(b0.htrans), 32'd2);
      chk("t6_post_addr_haddr", b0.haddr, 32'h600);
      cyc();
      chk("t6_post_i_done", 32'(b0.i_done), 32'd1);
      b0.i_req = 0;
      cyc();

      // Round-robin: both keep requesting, grants alternate D, I, D, I
      b1.i_req = 1; b1.i_addr = 32'h1000;
      b1.d_ren = 1; b1.d_addr = 32'h2000; b1.d_size = 2'b10; b1.hrdata = 32'h5EED_0002;
      q1.push_back('{1'b1, 1'b0, 1'b1, 32'h5EED_0002});
      q1.push_back('{1'b0, 1'b0, 1'b1, 32'h5EED_0002});
      q1.push_back('{1'b1, 1'b0, 1'b1, 32'h5EED_0002});
      q1.push_back('{1'b0, 1'b0, 1'b1, 32'h5EED_0002});
      for (int k = 0; k < 4; k++) begin
         cyc();
         wait_done(1, gd);
         chk($sformatf("t4_grant_%0d", k), 32'(gd), 32'((k % 2) == 0));
         if (k == 3) begin
            b1.i_req = 0; b1.d_ren = 0;
         end
      end
      cyc();
      cyc();
      chk("t4_idle_htrans", 32'(b1.htrans), 32'd0);

      chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
      chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
